// File: rtl/mmio_defs.sv
// rtl/mmio_defs.sv - shared MMIO address map and register offsets for the input port
package mmio_defs;

  localparam logic [31:0] MMIO_DISP_ADDR  = 32'h4000_0010;
  localparam logic [31:0] MMIO_INPUT_BASE = 32'h4000_0020;
  localparam int          CTRL_IRQ_EN_BIT = 0;

  typedef enum logic [1:0] {
    OFF_SW   = 2'd0,
    OFF_BTN  = 2'd1,
    OFF_EDGE = 2'd2,
    OFF_CTRL = 2'd3
  } mmio_off_e;

  // A 16-byte window: only the upper 28 address bits take part in decode.
  function automatic logic mmio_window_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/input_debounce_bit.sv
// rtl/input_debounce_bit.sv - 2-flop synchronizer plus optional debounce counter for one input
// Debounce counter present only when MMIO_INPUT_DEBOUNCE_EN is defined.
module input_debounce_bit #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  if (DEBOUNCE_CYCLES < 16'd2) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

`ifdef MMIO_INPUT_DEBOUNCE_EN
  localparam int CW = $clog2(int'(DEBOUNCE_CYCLES));
  localparam logic [CW-1:0] TERM = CW'(int'(DEBOUNCE_CYCLES) - 1);

  logic          sync1_q, sync2_q, stable_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      // Any sample that agrees with stable restarts the count, so glitches never land.
      if (sync2_q != stable_q) begin
        if (cnt_q == TERM) begin
          stable_q <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end
`else
  logic sync_q, stable_q;

  // Without debounce the stable flop doubles as the second synchronizer stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= raw;
      stable_q <= sync_q;
    end
  end
`endif

  assign stable = stable_q;

endmodule

// File: rtl/mmio_input_port.sv
// rtl/mmio_input_port.sv - memory-mapped switch/button input port with edge flags and irq
// Debounce is enabled with MMIO_INPUT_DEBOUNCE_EN; otherwise inputs are only synchronized.
module mmio_input_port
  import mmio_defs::*;
#(
  parameter logic [31:0] BASE_ADDR       = MMIO_INPUT_BASE,
  parameter int          N_SW            = 8,
  parameter int          N_BTN           = 4,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Address,
  input  logic [31:0]      Write_data,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [31:0]      Read_data,
  output logic             Hit,
  input  logic [N_SW-1:0]  switches,
  input  logic [N_BTN-1:0] buttons,
  output logic             irq
);

  logic [N_SW-1:0]  sw_stable;
  logic [N_BTN-1:0] btn_stable;
  logic [N_BTN-1:0] btn_prev_q;
  logic [N_BTN-1:0] edge_q;
  logic [N_BTN-1:0] edge_set, edge_clr;
  logic             irq_en_q, irq_q;
  logic             wr_hit;
  mmio_off_e        offset;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    input_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .raw(switches[i]), .stable(sw_stable[i])
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    input_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .raw(buttons[i]), .stable(btn_stable[i])
    );
  end

  assign Hit    = mmio_window_hit(Address, BASE_ADDR);
  assign offset = mmio_off_e'(Address[3:2]);
  assign wr_hit = MemWrite && Hit;

  always_comb begin
    Read_data = 32'h0;
    if (MemRead && Hit) begin
      case (offset)
        OFF_SW:   Read_data = 32'(sw_stable);
        OFF_BTN:  Read_data = 32'(btn_stable);
        OFF_EDGE: Read_data = 32'(edge_q);
        OFF_CTRL: Read_data = {31'h0, irq_en_q};
        default:  Read_data = 32'h0;
      endcase
    end
  end

  assign edge_set = btn_stable & ~btn_prev_q;
  assign edge_clr = (wr_hit && offset == OFF_EDGE) ? Write_data[N_BTN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev_q <= '0;
      edge_q     <= '0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      btn_prev_q <= btn_stable;
      // Set is OR'd after the clear so a fresh edge survives a same-cycle W1C.
      edge_q     <= (edge_q & ~edge_clr) | edge_set;
      irq_q      <= irq_en_q & (|edge_q);
      if (wr_hit && offset == OFF_CTRL) begin
        irq_en_q <= Write_data[CTRL_IRQ_EN_BIT];
      end
    end
  end

  assign irq = irq_q;

  logic unused_bits;
  assign unused_bits = ^{Address[1:0], Write_data[31:N_BTN]};

endmodule

// File: tb/tb_mmio_input_port.sv
// tb/tb_mmio_input_port.sv - scoreboard bench for mmio_input_port against a raw-history model
module tb_mmio_input_port;

  localparam int DC = 8;
`ifdef MMIO_INPUT_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] BASE = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = 32'h0;
  logic [31:0] Write_data = 32'h0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        Hit;
  logic [7:0]  switches = 8'h0;
  logic [3:0]  buttons = 4'h0;
  logic        irq;

  mmio_input_port #(
    .BASE_ADDR(BASE), .N_SW(8), .N_BTN(4), .DEBOUNCE_CYCLES(16'(DC))
  ) dut (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data), .Hit(Hit),
    .switches(switches), .buttons(buttons), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: rh[k] holds the raw inputs sampled k+1 edges ago; a bit flips once
  // the last DC synchronized samples all disagree with its stable value.
  logic [11:0] rh [0:DC];
  logic [11:0] m_st;
  logic [3:0]  m_bprev, m_edge;
  logic        m_en, m_irq;

  always @(posedge clk) begin
    logic [11:0] nst;
    logic [3:0]  clr, nedge;
    logic        hitw, flip;
    if (reset) begin
      for (int k = 0; k <= DC; k++) rh[k] = 12'h0;
      m_st = 12'h0; m_bprev = 4'h0; m_edge = 4'h0; m_en = 1'b0; m_irq = 1'b0;
    end else begin
      hitw  = MemWrite && (Address[31:4] == BASE[31:4]);
      clr   = (hitw && Address[3:2] == 2'd2) ? Write_data[3:0] : 4'h0;
      nedge = (m_edge & ~clr) | (m_st[11:8] & ~m_bprev);
      m_irq = m_en & (|m_edge);
      if (hitw && Address[3:2] == 2'd3) m_en = Write_data[0];
      m_bprev = m_st[11:8];
      m_edge  = nedge;
`ifdef MMIO_INPUT_DEBOUNCE_EN
      for (int b = 0; b < 12; b++) begin
        flip = 1'b1;
        for (int k = 1; k <= DC; k++) if (rh[k][b] == m_st[b]) flip = 1'b0;
        nst[b] = flip ? ~m_st[b] : m_st[b];
      end
`else
      nst = rh[0];
`endif
      m_st = nst;
      for (int k = DC; k >= 1; k--) rh[k] = rh[k-1];
      rh[0] = {buttons, switches};
    end
  end

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
    logic        irq;
    logic [31:0] addr;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic exp_t predict(input logic rd, input logic [31:0] addr);
    exp_t e;
    e.addr = addr;
    e.hit  = (addr[31:4] == BASE[31:4]);
    e.irq  = m_irq;
    e.data = 32'h0;
    if (rd && e.hit) begin
      case (addr[3:2])
        2'd0: e.data = {24'h0, m_st[7:0]};
        2'd1: e.data = {28'h0, m_st[11:8]};
        2'd2: e.data = {28'h0, m_edge};
        default: e.data = {31'h0, m_en};
      endcase
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] addr,
                       input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s addr=%h actual=%h required=%h t=%0t", name, addr, act, req, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (MemRead || MemWrite) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", Address, 32'h1, 32'h0);
      end else begin
        e = sbq.pop_front();
        check("hit", e.addr, {31'h0, Hit}, {31'h0, e.hit});
        check("read_data", e.addr, Read_data, e.data);
        check("irq", e.addr, {31'h0, irq}, {31'h0, e.irq});
      end
    end
  end

  task automatic cyc(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    MemRead = rd; MemWrite = wr; Address = addr; Write_data = wd;
    if (rd || wr) sbq.push_back(predict(rd, addr));
  endtask

  task automatic rd_n(input logic [31:0] addr, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, addr, 32'h0);
  endtask

  initial begin
    int sel;
    logic [31:0] a;
    reset = 1'b1;
    rd_n(BASE, 3);
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    // Reset values, misses, and a store-only cycle on a hit address.
    rd_n(BASE + 0, 1); rd_n(BASE + 4, 1); rd_n(BASE + 8, 1); rd_n(BASE + 12, 1);
    rd_n(BASE + 13, 1); rd_n(32'h4000_0030, 1); rd_n(32'h4000_0010, 1);
    cyc(1'b0, 1'b1, BASE, 32'hFFFF_FFFF);

    switches = 8'hA5;
    rd_n(BASE, LAT + 3);

    buttons[2] = 1'b1; rd_n(BASE + 4, 5);
    buttons[2] = 1'b0; rd_n(BASE + 8, LAT + 3);
    buttons[2] = 1'b1; rd_n(BASE + 4, 20);
    rd_n(BASE + 8, 1);
    buttons[2] = 1'b0; rd_n(BASE + 4, LAT + 2);
    cyc(1'b0, 1'b1, BASE + 8, 32'hF);

    cyc(1'b0, 1'b1, BASE + 12, 32'h1);
    buttons[1] = 1'b1; rd_n(BASE + 8, LAT + 4);
    cyc(1'b0, 1'b1, BASE + 8, 32'h2);
    rd_n(BASE + 8, 3);
    cyc(1'b0, 1'b1, BASE, 32'h0);
    rd_n(BASE, 2);
    buttons[1] = 1'b0; rd_n(BASE + 4, LAT + 2);

    // Same-cycle W1C and newly stable rising edge on button 0.
    buttons[0] = 1'b1; rd_n(BASE + 8, LAT + 3);
    buttons[0] = 1'b0; rd_n(BASE + 8, LAT + 3);
    buttons[0] = 1'b1; rd_n(BASE + 8, LAT - 1);
    cyc(1'b0, 1'b1, BASE + 8, 32'h1);
    rd_n(BASE + 8, 3);
    buttons[0] = 1'b0; rd_n(BASE + 8, LAT + 2);
    cyc(1'b0, 1'b1, BASE + 8, 32'hF);

    switches = 8'h00; rd_n(BASE, LAT + 2);
    switches = 8'hFF; rd_n(BASE, 7);
    reset = 1'b1; rd_n(BASE, 1);
    reset = 1'b0; rd_n(BASE, LAT + 3);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) switches[$urandom_range(7)] ^= 1'b1;
      if ($urandom_range(11) == 0) buttons[$urandom_range(3)] ^= 1'b1;
      if ($urandom_range(40) == 0) switches = 8'($urandom);
      sel = $urandom_range(9);
      a = BASE + 32'($urandom_range(15));
      if (sel < 6)       cyc(1'b1, 1'b0, a, 32'h0);
      else if (sel == 6) cyc(1'b0, 1'b1, BASE + 8, $urandom);
      else if (sel == 7) cyc(1'b0, 1'b1, BASE + 12, $urandom);
      else if (sel == 8) cyc(1'b1, 1'b0, ($urandom_range(1) != 0) ? 32'h4000_0030 : 32'h4000_001C, 32'h0);
      else               cyc(1'b0, 1'b0, 32'h0, 32'h0);
    end

    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check("sb_drained", 32'h0, 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
